// File: rtl/seven_seg_scan_driver.sv
// Scans four BCD digits onto a common-anode display with dead time, colon and field blink.
// Optional build macro LEAD_ZERO_BLANK_EN blanks the hours-tens digit when it is zero.
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 250000,
    parameter int unsigned DEAD_CYC    = 16,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic       adjust,
    input  logic       adj_hours,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [1:0]         sh_h1_q, sh_h1_d;
    logic [3:0]         sh_h2_q, sh_h2_d;
    logic [2:0]         sh_m1_q, sh_m1_d;
    logic [3:0]         sh_m2_q, sh_m2_d;
    logic [3:0]         anode_q, anode_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               presc_wrap;
    logic               blink_wrap;
    logic               field_sel;
    logic               lz_blank;
    logic               blank;
    logic [3:0]         digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Next-state for counters and shadow digits, and registered display outputs.
    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        sh_h1_d       = sh_h1_q;
        sh_h2_d       = sh_h2_q;
        sh_m1_d       = sh_m1_q;
        sh_m2_d       = sh_m2_q;
        anode_d       = 4'b1111;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        digit         = 4'd0;
        lz_blank      = 1'b0;

        presc_wrap = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + PRESC_W'(1);
        if (presc_wrap) begin
            idx_d = idx_q + 2'd1;
        end

        // Capture only at the frame boundary so one frame never mixes old and new time.
        if (presc_wrap && (idx_q == 2'd3)) begin
            sh_h1_d = H1;
            sh_h2_d = H2;
            sh_m1_d = M1;
            sh_m2_d = M2;
        end

        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        if (blink_wrap) begin
            blink_phase_d = ~blink_phase_q;
        end

        case (idx_q)
            2'd0:    digit = sh_m2_q;
            2'd1:    digit = {1'b0, sh_m1_q};
            2'd2:    digit = sh_h2_q;
            default: digit = {2'b00, sh_h1_q};
        endcase

`ifdef LEAD_ZERO_BLANK_EN
        lz_blank = (idx_q == 2'd3) && (sh_h1_q == 2'd0);
`else
        lz_blank = 1'b0;
`endif

        field_sel = adj_hours ? idx_q[1] : ~idx_q[1];
        blank = (presc_q < PRESC_W'(DEAD_CYC))
              || (adjust && blink_phase_q && field_sel)
              || lz_blank;

        if (!blank) begin
            anode_d = ~(4'b0001 << idx_q);
            seg_d   = decode(digit);
            dp_d    = ~((idx_q == 2'd2) && (adjust || !blink_phase_q));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_h1_q       <= 2'd0;
            sh_h2_q       <= 4'd0;
            sh_m1_q       <= 3'd0;
            sh_m2_q       <= 4'd0;
            anode_q       <= 4'b1111;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_h1_q       <= sh_h1_d;
            sh_h2_q       <= sh_h2_d;
            sh_m1_q       <= sh_m1_d;
            sh_m2_q       <= sh_m2_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8, DEAD_CYC=2, BLINK_DIV=64.
// Output sample "s" reflects prescaler=s%8, slot=(s/8)%4, blink_phase=(s/64)%2 after reset release.
module tb_seven_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [1:0] H1;
    logic [3:0] H2;
    logic [2:0] M1;
    logic [3:0] M2;
    logic       adjust;
    logic       adj_hours;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    int tests;
    int fails;
    int shown;

    seven_seg_scan_driver #(
        .REFRESH_DIV(8),
        .DEAD_CYC   (2),
        .BLINK_DIV  (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .H1       (H1),
        .H2       (H2),
        .M1       (M1),
        .M2       (M2),
        .adjust   (adjust),
        .adj_hours(adj_hours),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one anode may be low in any sampled cycle.
    always @(negedge clk) begin
        tests++;
        assert ($countones(~anode) <= 1)
        else begin
            fails++;
            $error("FAIL onehot: anode=%b expected at most one low bit", anode);
        end
    end

    initial begin
        #50000;
        fails++;
        $display("FAIL watchdog: simulation time exceeded");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] ea, input logic [6:0] es,
                         input logic ed);
        tests++;
        assert (anode === ea && seg === es && dp === ed)
        else begin
            fails++;
            $error("FAIL %s: anode=%b seg=%h dp=%b expected anode=%b seg=%h dp=%b",
                   tag, anode, seg, dp, ea, es, ed);
        end
    endtask

    task automatic show(input int s);
        while (shown < s) begin
            @(negedge clk);
            shown++;
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        shown     = -1;
        rst       = 1'b0;
        H1        = 2'd1;
        H2        = 4'd2;
        M1        = 3'd3;
        M2        = 4'd4;
        adjust    = 1'b0;
        adj_hours = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 4'b1111, 7'h7F, 1'b1);
        rst = 1'b1;

        // Frame 0 shows zeros from the reset shadow.
        show(0);   check("f0_dead0",  4'b1111, 7'h7F, 1'b1);
        show(1);   check("f0_dead1",  4'b1111, 7'h7F, 1'b1);
        show(2);   check("f0_slot0",  4'b1110, 7'h40, 1'b1);
        show(10);  check("f0_slot1",  4'b1101, 7'h40, 1'b1);
        show(18);  check("f0_slot2",  4'b1011, 7'h40, 1'b0);
`ifdef LEAD_ZERO_BLANK_EN
        show(26);  check("f0_slot3_lz", 4'b1111, 7'h7F, 1'b1);
`else
        show(26);  check("f0_slot3",  4'b0111, 7'h40, 1'b1);
`endif

        // Frame 1 shows captured 12:34.
        show(32);  check("f1_dead",   4'b1111, 7'h7F, 1'b1);
        show(34);  check("f1_m2",     4'b1110, 7'h19, 1'b1);
        show(40);  check("f1_dead1",  4'b1111, 7'h7F, 1'b1);
        show(42);  check("f1_m1",     4'b1101, 7'h30, 1'b1);
        M2 = 4'd5;
        H1 = 2'd2;
        show(50);  check("f1_h2",     4'b1011, 7'h24, 1'b0);
        show(58);  check("f1_h1_old", 4'b0111, 7'h79, 1'b1);

        // Frame 2: new digits, blink_phase=1 so run-mode colon is off.
        show(66);  check("f2_m2_new", 4'b1110, 7'h12, 1'b1);
        show(82);  check("f2_h2_dp1", 4'b1011, 7'h24, 1'b1);
        show(90);  check("f2_h1_new", 4'b0111, 7'h24, 1'b1);
        show(146); check("f4_h2_dp0", 4'b1011, 7'h24, 1'b0);

        // Adjust hours: steady colon, hours blank while blink_phase=1.
        show(150);
        adjust    = 1'b1;
        adj_hours = 1'b1;
        show(178); check("adj_h2_ph0", 4'b1011, 7'h24, 1'b0);
        show(194); check("adj_m2_ph1", 4'b1110, 7'h12, 1'b1);
        show(202); check("adj_m1_ph1", 4'b1101, 7'h30, 1'b1);
        show(210); check("adj_h2_blk", 4'b1111, 7'h7F, 1'b1);
        show(218); check("adj_h1_blk", 4'b1111, 7'h7F, 1'b1);

        // Adjust minutes, then leave adjust mid-blink.
        show(220);
        adj_hours = 1'b0;
        show(226); check("adjm_m2_blk", 4'b1111, 7'h7F, 1'b1);
        adjust = 1'b0;
        show(227); check("leave_adj",   4'b1110, 7'h12, 1'b1);
        show(242); check("run_dp_ph1",  4'b1011, 7'h24, 1'b1);

        // Out-of-range digit renders as a dash.
        show(245);
        H2 = 4'hC;
        show(274); check("h2_dash",   4'b1011, 7'h3F, 1'b0);
        show(284); check("pre_reset", 4'b0111, 7'h24, 1'b1);

        // Asynchronous reset mid-slot 3, then scanning restarts at slot 0.
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        shown = -1;
        show(0);   check("rs_dead",  4'b1111, 7'h7F, 1'b1);
        show(2);   check("rs_slot0", 4'b1110, 7'h40, 1'b1);
        show(10);  check("rs_slot1", 4'b1101, 7'h40, 1'b1);
`ifdef LEAD_ZERO_BLANK_EN
        show(26);  check("rs_slot3_lz", 4'b1111, 7'h7F, 1'b1);
`else
        show(26);  check("rs_slot3", 4'b0111, 7'h40, 1'b1);
`endif
        show(34);  check("rs_f1_m2", 4'b1110, 7'h12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Downstream consumer of the timekeeping stage's BCD digit outputs (H1, H2, M1, M2). It time-multiplexes the four digits onto a common-anode 4-digit seven-segment display. It includes anti-ghosting dead time, a centre colon, and blinking of the field under adjustment. Digits are captured once per scan frame so a rollover never shows a torn frame.

Parameters:
REFRESH_DIV, 250000, clk cycles per digit slot (400 Hz slot rate at 100 MHz)
DEAD_CYC, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
BLINK_DIV, 50000000, clk cycles per blink_phase toggle (1 Hz blink at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
H1  in  2  hours tens digit
H2  in  4  hours units digit
M1  in  3  minutes tens digit
M2  in  4  minutes units digit
adjust  in  1  1 = time-adjust mode
adj_hours  in  1  in adjust mode: 1 = hours field blinks, 0 = minutes field blinks
anode  out  4  digit enables, active-low; anode[0] = M2 (rightmost) ... anode[3] = H1
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  colon, active-low; asserted only during the anode[2] slot

Behaviour:
- Reset (rst=0, async):
  - anode=4'b1111, seg=7'h7F, dp=1.
  - Prescaler=0, slot index=0, blink counter=0, blink_phase=0, shadow digits=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, slot index advances 0→1→2→3→0.
- Shadow capture:
  - When the prescaler wraps with index==3, latch H1,H2,M1,M2 into shadow registers.
  - The next frame (index 0..3) displays only the shadow values.
  - After reset, the first frame shows zeros.
- Blink counter:
  - Counts 0..BLINK_DIV-1; toggles blink_phase on wrap.
  - Free-running, independent of adjust.
- Blank condition for the current slot is true if any of:
  - prescaler < DEAD_CYC (dead time);
  - adjust=1 and blink_phase=1 and the slot belongs to the selected field (hours = idx 2,3; minutes = idx 0,1).
- Decode (shadow digit of current slot, zero-extended to 4 bits):
  - 0-9 → standard patterns (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Values 10-15 → dash (seg=7'h3F).
- Outputs are registered, one cycle of latency from index/prescaler state:
  - blank → anode=4'b1111, seg=7'h7F, dp=1;
  - else → anode = one-hot-low of index, seg = decode.
  - dp=0 only when idx==2, not blanked, and (adjust=1 or blink_phase=0). In run mode the colon blinks; in adjust mode it is steady.
- Mode changes:
  - adjust/adj_hours are sampled every cycle and take effect on the following output register update.
  - Leaving adjust mid-blink restores the field the next cycle.
- Exclusivity: never more than one anode low in any cycle, including across slot transitions and reset release.
- Reset mid-frame: immediate return to reset values; scanning restarts at index 0.

Optional Feature:
LEAD_ZERO_BLANK_EN:
- Defined: when shadow H1==0, the anode[3] slot is treated as blanked (digit dark, anode high); timing is unchanged.
- Undefined: H1==0 displays "0".

Test Plan:
All scenarios use REFRESH_DIV=8, DEAD_CYC=2, BLINK_DIV=64.
1. Reset then run, inputs H1=1,H2=2,M1=3,M2=4, adjust=0 → first frame shows seg=7'h40 on all slots. Second frame, anode sequence 1110,1101,1011,0111 with seg 7'h19,7'h30,7'h24,7'h79. Each slot has 2 dead cycles with anode=1111.
2. Change M2 from 4 to 5 mid-frame at idx 1 → the current frame still shows 4. The next frame shows 5 (7'h12).
3. adjust=1, adj_hours=1 → while blink_phase=1, slots 2,3 have anode=1111 and slots 0,1 are normal. dp=0 in every slot 2 window that is outside the blink-blank, and never in other slots.
4. adjust=0 → dp toggles with blink_phase: low during slot 2 when blink_phase=0, high when blink_phase=1.
5. Digit out of range (H2=4'hC) → seg=7'h3F in the slot 2 window.
6. Assert rst low mid-slot 3 → outputs go 1111/7'h7F/1 asynchronously. After release, scanning restarts at index 0 and the one-hot anode check holds every cycle. With LEAD_ZERO_BLANK_EN and H1=0, the slot 3 anode stays 1111.
